// File: rtl/sh7604_ibus_initiator_pkg.sv
// Shared types and helpers for the SH7604 internal-bus initiator.
package sh7604_ibus_initiator_pkg;

    typedef enum logic [1:0] {
        IBUS_SZ_BYTE = 2'b00,
        IBUS_SZ_WORD = 2'b01,
        IBUS_SZ_LONG = 2'b10,
        IBUS_SZ_RSV  = 2'b11
    } IBUS_SZ_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } IBUS_STATE_t;

    // Byte enables, bit 3 = bits 31:24 (big-endian lane order).
    function automatic logic [3:0] IBUS_BA_GEN(input IBUS_SZ_t sz, input logic [1:0] a10);
        case (sz)
            IBUS_SZ_BYTE: IBUS_BA_GEN = 4'b1000 >> a10;
            IBUS_SZ_WORD: IBUS_BA_GEN = a10[1] ? 4'b0011 : 4'b1100;
            IBUS_SZ_LONG: IBUS_BA_GEN = 4'b1111;
            default:      IBUS_BA_GEN = 4'b0000;
        endcase
    endfunction

    function automatic logic IBUS_CMD_BAD(input IBUS_SZ_t sz, input logic [1:0] a10);
        case (sz)
            IBUS_SZ_BYTE: IBUS_CMD_BAD = 1'b0;
            IBUS_SZ_WORD: IBUS_CMD_BAD = a10[0];
            IBUS_SZ_LONG: IBUS_CMD_BAD = (a10 != 2'b00);
            default:      IBUS_CMD_BAD = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sh7604_ibus_initiator_if.sv
// Core command/response port plus IBUS master signals for the SH7604 initiator.
interface sh7604_ibus_initiator_if;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [31:0] CMD_A;
    logic        CMD_WE;
    logic [1:0]  CMD_SZ;
    logic [31:0] CMD_D;
    logic        RSP_VALID;
    logic [31:0] RSP_D;
    logic        RSP_ERR;
    logic [31:0] IBUS_A;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic [31:0] IBUS_DI;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;

    modport master (
        input  CMD_VALID, CMD_A, CMD_WE, CMD_SZ, CMD_D, IBUS_DI, IBUS_BUSY, IBUS_ACT,
        output CMD_READY, RSP_VALID, RSP_D, RSP_ERR, IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ
    );

    modport slave (
        output CMD_VALID, CMD_A, CMD_WE, CMD_SZ, CMD_D, IBUS_DI, IBUS_BUSY, IBUS_ACT,
        input  CMD_READY, RSP_VALID, RSP_D, RSP_ERR, IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ
    );
endinterface

// File: rtl/sh7604_ibus_lane.sv
// Combinational byte-lane steering for IBUS writes and right-justified read extraction.
module sh7604_ibus_lane
    import sh7604_ibus_initiator_pkg::*;
(
    input  IBUS_SZ_t    wsz,
    input  logic [1:0]  wa10,
    input  logic [31:0] wdata,
    output logic [3:0]  ba,
    output logic [31:0] wlane,
    input  IBUS_SZ_t    rsz,
    input  logic [1:0]  ra10,
    input  logic [31:0] di,
    output logic [31:0] rdata
);
    logic [31:0] di_byte;

    assign ba = IBUS_BA_GEN(wsz, wa10);

    always_comb begin
        case (wsz)
            IBUS_SZ_BYTE: wlane = {4{wdata[7:0]}};
            IBUS_SZ_WORD: wlane = {2{wdata[15:0]}};
            IBUS_SZ_LONG: wlane = wdata;
            default:      wlane = 32'h0;
        endcase
    end

    // ~a10 equals 3-a10, so this lands the addressed byte in bits 7:0.
    assign di_byte = di >> {~ra10, 3'b000};

    always_comb begin
        case (rsz)
            IBUS_SZ_BYTE: rdata = {24'h0, di_byte[7:0]};
            IBUS_SZ_WORD: rdata = {16'h0, (ra10[1] ? di[15:0] : di[31:16])};
            IBUS_SZ_LONG: rdata = di;
            default:      rdata = 32'h0;
        endcase
    end
endmodule

// File: rtl/sh7604_ibus_initiator.sv
// SH7604 IBUS initiator: one outstanding access, slave wait states, one-tick response strobe.
// Define IBUS_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYCLES CE_R ticks.
module sh7604_ibus_initiator
    import sh7604_ibus_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CE_R,
    input  logic CE_F,
    input  logic RES_N,
    sh7604_ibus_initiator_if.master bus
);
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $fatal(1, "TIMEOUT_CYCLES must be at least 2");
    end

    IBUS_STATE_t state_q, state_d;
    IBUS_SZ_t    sz_q, sz_d;
    logic        ready_q, ready_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] a_q, a_d;
    logic [31:0] do_q, do_d;
    logic [3:0]  ba_q, ba_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_d_q, rsp_d_d;
    logic        fall_seen_q, fall_seen_d;

    IBUS_SZ_t    cmd_sz;
    logic        cmd_bad;
    logic [3:0]  ba_cmd;
    logic [31:0] do_cmd;
    logic [31:0] rd_ext;

`ifdef IBUS_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    assign cmd_sz  = IBUS_SZ_t'(bus.CMD_SZ);
    assign cmd_bad = IBUS_CMD_BAD(cmd_sz, bus.CMD_A[1:0]);

    sh7604_ibus_lane u_lane (
        .wsz   (cmd_sz),
        .wa10  (bus.CMD_A[1:0]),
        .wdata (bus.CMD_D),
        .ba    (ba_cmd),
        .wlane (do_cmd),
        .rsz   (sz_q),
        .ra10  (a_q[1:0]),
        .di    (bus.IBUS_DI),
        .rdata (rd_ext)
    );

    always_comb begin
        state_d     = state_q;
        sz_d        = sz_q;
        ready_d     = ready_q;
        req_d       = req_q;
        we_d        = we_q;
        a_d         = a_q;
        do_d        = do_q;
        ba_d        = ba_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_d_d     = rsp_d_q;
        fall_seen_d = fall_seen_q;
`ifdef IBUS_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        // Read data is only trusted once the slave has had a falling phase to drive it.
        if (CE_F && req_q) fall_seen_d = 1'b1;

        if (CE_R) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.CMD_VALID) begin
                        ready_d = 1'b0;
                        if (cmd_bad) begin
                            state_d     = ST_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_d_d     = '0;
                        end else begin
                            state_d     = ST_ISSUE;
                            a_d         = bus.CMD_A;
                            we_d        = bus.CMD_WE;
                            sz_d        = cmd_sz;
                            ba_d        = ba_cmd;
                            do_d        = do_cmd;
                            req_d       = 1'b1;
                            fall_seen_d = 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!bus.IBUS_ACT) begin
                        state_d     = ST_RESP;
                        req_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_d_d     = '0;
                    end else begin
                        state_d = ST_WAIT;
`ifdef IBUS_TIMEOUT_EN
                        tmo_cnt_d = '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (!bus.IBUS_BUSY && fall_seen_q) begin
                        state_d     = ST_RESP;
                        req_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_d_d     = we_q ? 32'h0 : rd_ext;
                    end
`ifdef IBUS_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        state_d     = ST_RESP;
                        req_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_d_d     = '0;
                    end else if (tmo_cnt_q != '1) begin
                        tmo_cnt_d = tmo_cnt_q + CNT_ONE;
                    end
`endif
                end
                ST_RESP: begin
                    state_d     = ST_IDLE;
                    ready_d     = 1'b1;
                    rsp_valid_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase

            // Soft reset abandons any transfer silently.
            if (!RES_N) begin
                state_d     = ST_IDLE;
                sz_d        = IBUS_SZ_BYTE;
                ready_d     = 1'b1;
                req_d       = 1'b0;
                we_d        = 1'b0;
                a_d         = '0;
                do_d        = '0;
                ba_d        = '0;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_d_d     = '0;
                fall_seen_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            sz_q        <= IBUS_SZ_BYTE;
            ready_q     <= 1'b1;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            a_q         <= '0;
            do_q        <= '0;
            ba_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_d_q     <= '0;
            fall_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sz_q        <= sz_d;
            ready_q     <= ready_d;
            req_q       <= req_d;
            we_q        <= we_d;
            a_q         <= a_d;
            do_q        <= do_d;
            ba_q        <= ba_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_d_q     <= rsp_d_d;
            fall_seen_q <= fall_seen_d;
        end
    end

    assign bus.CMD_READY = ready_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_ERR   = rsp_err_q;
    assign bus.RSP_D     = rsp_d_q;
    assign bus.IBUS_A    = a_q;
    assign bus.IBUS_DO   = do_q;
    assign bus.IBUS_BA   = ba_q;
    assign bus.IBUS_WE   = we_q;
    assign bus.IBUS_REQ  = req_q;
endmodule

// File: tb/tb_sh7604_ibus_initiator.sv
// Scoreboard bench for sh7604_ibus_initiator; CE_R and CE_F alternate on successive clocks.
module tb_sh7604_ibus_initiator;
    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    logic CE_R  = 1'b0;
    logic CE_F  = 1'b0;
    logic RES_N = 1'b1;

    int unsigned tick_n = 0;
    int          n_chk  = 0;
    int          n_pass = 0;

    typedef struct {
        logic        err;
        logic        chk_d;
        logic [31:0] d;
        int unsigned acc;
        int unsigned lat;
    } exp_t;
    exp_t sb[$];

    sh7604_ibus_initiator_if ifc();

    sh7604_ibus_initiator #(.TIMEOUT_CYCLES(255)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CE_R  (CE_R),
        .CE_F  (CE_F),
        .RES_N (RES_N),
        .bus   (ifc)
    );

    always #5 CLK = ~CLK;

    // tick_n always names the CE_R edge that comes next.
    initial forever begin
        @(posedge CLK);
        #2;
        CE_R = ~CE_R;
        CE_F = ~CE_R;
        if (CE_R) tick_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (CE_R && ifc.RSP_VALID === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_err", {31'h0, ifc.RSP_ERR}, {31'h0, e.err});
                    if (e.chk_d) chk("rsp_d", ifc.RSP_D, e.d);
                    chk("rsp_lat", tick_n - e.acc, e.lat);
                end
            end
        end
    end

    task automatic wait_tick();
        do @(negedge CLK); while (!CE_R);
    endtask

    task automatic send(input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic [31:0] d, output int unsigned acc);
        int guard = 0;
        ifc.CMD_A = a; ifc.CMD_WE = we; ifc.CMD_SZ = sz; ifc.CMD_D = d; ifc.CMD_VALID = 1'b1;
        while (!(CE_R && ifc.CMD_READY === 1'b1) && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 100) chk("accept_timeout", 32'd0, 32'd1);
        acc = tick_n;
        @(negedge CLK);
        ifc.CMD_VALID = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge CLK);
        if (sb.size() != 0) begin
            chk({tag, "_rsp_missing"}, 32'd0, 32'd1);
            sb.delete();
        end
        wait_tick();
        wait_tick();
        chk({tag, "_ready"}, {31'h0, ifc.CMD_READY}, 32'd1);
        chk({tag, "_req_end"}, {31'h0, ifc.IBUS_REQ}, 32'd0);
    endtask

    task automatic xfer(input string tag, input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic [31:0] d, input logic [31:0] di, input logic act, input int busy_ticks,
                        input logic exp_err, input logic [31:0] exp_d, input int unsigned exp_lat,
                        input logic bus_cycle, input logic [3:0] exp_ba, input logic [31:0] exp_do);
        int unsigned acc;
        exp_t e;
        ifc.IBUS_DI = di; ifc.IBUS_ACT = act; ifc.IBUS_BUSY = (busy_ticks > 0);
        send(a, we, sz, d, acc);
        e.err = exp_err; e.chk_d = !we && !exp_err; e.d = exp_d; e.acc = acc; e.lat = exp_lat;
        sb.push_back(e);
        if (bus_cycle) begin
            chk({tag, "_ba"}, {28'h0, ifc.IBUS_BA}, {28'h0, exp_ba});
            chk({tag, "_do"}, ifc.IBUS_DO, exp_do);
            chk({tag, "_a"}, ifc.IBUS_A, a);
            chk({tag, "_we"}, {31'h0, ifc.IBUS_WE}, {31'h0, we});
            for (int i = 0; i <= busy_ticks; i++) begin
                wait_tick();
                chk({tag, "_req_hold"}, {31'h0, ifc.IBUS_REQ}, {31'h0, (act | (i == 0))});
                chk({tag, "_ba_hold"}, {28'h0, ifc.IBUS_BA}, {28'h0, exp_ba});
            end
            ifc.IBUS_BUSY = 1'b0;
        end else begin
            chk({tag, "_noreq"}, {31'h0, ifc.IBUS_REQ}, 32'd0);
        end
        wait_drain(tag);
    endtask

    initial begin
        int unsigned acc;
        ifc.CMD_VALID = 1'b0; ifc.CMD_A = '0; ifc.CMD_WE = 1'b0; ifc.CMD_SZ = 2'b00; ifc.CMD_D = '0;
        ifc.IBUS_DI = '0; ifc.IBUS_BUSY = 1'b0; ifc.IBUS_ACT = 1'b1;
        #1 RST_N = 1'b0;
        repeat (4) @(negedge CLK);
        RST_N = 1'b1;

        chk("rst_ready", {31'h0, ifc.CMD_READY}, 32'd1);
        chk("rst_req",   {31'h0, ifc.IBUS_REQ}, 32'd0);
        chk("rst_we",    {31'h0, ifc.IBUS_WE}, 32'd0);
        chk("rst_rspv",  {31'h0, ifc.RSP_VALID}, 32'd0);
        chk("rst_rspe",  {31'h0, ifc.RSP_ERR}, 32'd0);
        chk("rst_ba",    {28'h0, ifc.IBUS_BA}, 32'd0);
        chk("rst_a",     ifc.IBUS_A, 32'd0);
        chk("rst_do",    ifc.IBUS_DO, 32'd0);
        chk("rst_rspd",  ifc.RSP_D, 32'd0);
        repeat (2) @(negedge CLK);

        //   tag      addr        we  sz     wdata         di            act busy err exp_d        lat bus  ba       do
        xfer("lwr",  32'hFFFFFF04, 1, 2'b10, 32'h12345678, 32'h0,        1,  4,  0, 32'h0,        6, 1, 4'b1111, 32'h12345678);
        xfer("brd",  32'hFFFFFF0B, 0, 2'b00, 32'h0,        32'hAABBCCDD, 1,  0,  0, 32'h000000DD, 3, 1, 4'b0001, 32'h0);
        xfer("wwr",  32'hFFFFFF0E, 1, 2'b01, 32'h0000BEEF, 32'h0,        1,  0,  0, 32'h0,        3, 1, 4'b0011, 32'hBEEFBEEF);
        xfer("wrd",  32'hFFFFFF0C, 0, 2'b01, 32'h0,        32'h11223344, 1,  1,  0, 32'h00001122, 3, 1, 4'b1100, 32'h0);
        xfer("bwr",  32'hFFFFFF09, 1, 2'b00, 32'h0000005A, 32'h0,        1,  0,  0, 32'h0,        3, 1, 4'b0100, 32'h5A5A5A5A);
        xfer("brd0", 32'hFFFFFF08, 0, 2'b00, 32'h0,        32'hAABBCCDD, 1,  2,  0, 32'h000000AA, 4, 1, 4'b1000, 32'h0);
        xfer("lrd",  32'hFFFFFF00, 0, 2'b10, 32'h0,        32'h87654321, 1,  0,  0, 32'h87654321, 3, 1, 4'b1111, 32'h0);
        xfer("lmis", 32'hFFFFFF02, 0, 2'b10, 32'h0,        32'h0,        1,  0,  1, 32'h0,        1, 0, 4'b0000, 32'h0);
        xfer("szrs", 32'hFFFFFF00, 1, 2'b11, 32'hCAFEF00D, 32'h0,        1,  0,  1, 32'h0,        1, 0, 4'b0000, 32'h0);
        xfer("wmis", 32'hFFFFFF01, 0, 2'b01, 32'h0,        32'h0,        1,  0,  1, 32'h0,        1, 0, 4'b0000, 32'h0);
        xfer("noact",32'hFFFFFF30, 0, 2'b10, 32'h0,        32'h0,        0,  0,  1, 32'h0,        2, 1, 4'b1111, 32'h0);
        ifc.IBUS_ACT = 1'b1;

        // BUSY stuck high for the whole access.
        ifc.IBUS_BUSY = 1'b1;
        send(32'hFFFFFF10, 1'b0, 2'b10, 32'h0, acc);
`ifdef IBUS_TIMEOUT_EN
        begin
            exp_t e;
            e.err = 1'b1; e.chk_d = 1'b0; e.d = '0; e.acc = acc; e.lat = 257;
            sb.push_back(e);
        end
        wait_drain("tmo");
        ifc.IBUS_BUSY = 1'b0;
`else
        repeat (300) wait_tick();
        chk("stuck_req",   {31'h0, ifc.IBUS_REQ}, 32'd1);
        chk("stuck_ready", {31'h0, ifc.CMD_READY}, 32'd0);
        RES_N = 1'b0;
        @(negedge CLK);
        RES_N = 1'b1;
        ifc.IBUS_BUSY = 1'b0;
        chk("stuck_rst_req", {31'h0, ifc.IBUS_REQ}, 32'd0);
        wait_tick();
`endif

        // Soft reset while in WAIT: no response, bus released, port ready again.
        ifc.IBUS_BUSY = 1'b1;
        send(32'hFFFFFF20, 1'b0, 2'b10, 32'h0, acc);
        repeat (3) wait_tick();
        chk("sr_wait_req", {31'h0, ifc.IBUS_REQ}, 32'd1);
        RES_N = 1'b0;
        @(negedge CLK);
        RES_N = 1'b1;
        ifc.IBUS_BUSY = 1'b0;
        chk("sr_req",   {31'h0, ifc.IBUS_REQ}, 32'd0);
        chk("sr_ready", {31'h0, ifc.CMD_READY}, 32'd1);
        chk("sr_rspv",  {31'h0, ifc.RSP_VALID}, 32'd0);
        repeat (6) wait_tick();
        xfer("sr_next", 32'hFFFFFF24, 0, 2'b10, 32'h0, 32'h0BADC0DE, 1, 0, 0, 32'h0BADC0DE, 3, 1, 4'b1111, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
